rmii_receiver: RTL and testbench

- RMII (100 Mb/s) receive front end running on the 50 MHz PHY reference clock.
- Detects preamble and SFD on the RXD0/RXD1 dibit stream and assembles 8-bit bytes, LSB first.
- Pushes bytes into the downstream RX FIFO and tags the last byte of each frame with fifo_EOD_in.
- Sits between the PHY RMII pins and the RX FIFO of the MAC.

---
 rtl/rmii_receiver.sv | 138 +++++++++++++
 tb/tb_rmii_receiver.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/rmii_receiver.sv
// RMII receive front end: preamble/SFD hunt, LSB-first byte assembly, one-byte hold so EOD tags the last byte.
// Latency: a byte is written one cycle after the next byte completes, or one cycle after end of frame; fifo_afull truncates the frame with EOD.
module rmii_receiver (
  input  logic       REF_CLK,
  input  logic       arst,
  input  logic       CRS_DV,
  input  logic       RXD0,
  input  logic       RXD1,
  input  logic       fifo_afull,
  output logic [7:0] fifo_din,
  output logic       fifo_wren,
  output logic       fifo_EOD_in
);

  typedef enum logic [1:0] {IDLE, PREAMBLE, RECEIVE, DISCARD} state_t;

  state_t     state, state_n;
  logic [1:0] dib, dib_q;
  logic       low_q;
  logic [1:0] cnt, cnt_n;
  logic [7:0] acc, acc_n;
  logic [7:0] hold, hold_n;
  logic       hold_full, hold_full_n;
  logic [7:0] din_n;
  logic       wren_n, eod_n;
  logic       byte_done;
  logic [7:0] byte_val;

  assign dib = {RXD1, RXD0};

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    acc_n       = acc;
    hold_n      = hold;
    hold_full_n = hold_full;
    din_n       = fifo_din;
    wren_n      = 1'b0;
    eod_n       = 1'b0;
    byte_done   = 1'b0;
    byte_val    = acc;

    case (state)
      IDLE: begin
        if (CRS_DV && dib == 2'b01) state_n = PREAMBLE;
      end

      PREAMBLE: begin
        if (!CRS_DV) begin
          state_n = IDLE;
        end else if (dib == 2'b11) begin
          state_n     = RECEIVE;
          cnt_n       = 2'd0;
          acc_n       = 8'h00;
          hold_full_n = 1'b0;
        end else if (dib == 2'b10) begin
          state_n = DISCARD;
        end
      end

      RECEIVE: begin
        if (!CRS_DV) begin
          // A lone low cycle's dibit waits in dib_q until we know whether it was a toggle or the end.
          if (low_q) begin
            state_n     = IDLE;
            cnt_n       = 2'd0;
            hold_full_n = 1'b0;
            if (hold_full) begin
              wren_n = 1'b1;
              eod_n  = 1'b1;
              din_n  = hold;
            end
          end
        end else begin
          for (int i = 0; i < 2; i++) begin
            if (i == 1 || low_q) begin
              acc_n[{cnt_n, 1'b0} +: 2] = (i == 0) ? dib_q : dib;
              if (cnt_n == 2'd3) begin
                byte_done = 1'b1;
                byte_val  = acc_n;
              end
              cnt_n = cnt_n + 2'd1;
            end
          end
          if (byte_done) begin
            if (!hold_full) begin
              hold_n      = byte_val;
              hold_full_n = 1'b1;
            end else if (fifo_afull) begin
              wren_n      = 1'b1;
              eod_n       = 1'b1;
              din_n       = hold;
              hold_full_n = 1'b0;
              state_n     = DISCARD;
            end else begin
              wren_n = 1'b1;
              din_n  = hold;
              hold_n = byte_val;
            end
          end
        end
      end

      DISCARD: begin
        if (!CRS_DV && low_q) state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge REF_CLK or posedge arst) begin
    if (arst) begin
      state       <= IDLE;
      cnt         <= 2'd0;
      acc         <= 8'h00;
      hold        <= 8'h00;
      hold_full   <= 1'b0;
      dib_q       <= 2'b00;
      low_q       <= 1'b0;
      fifo_din    <= 8'h00;
      fifo_wren   <= 1'b0;
      fifo_EOD_in <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      acc         <= acc_n;
      hold        <= hold_n;
      hold_full   <= hold_full_n;
      dib_q       <= dib;
      low_q       <= !CRS_DV;
      fifo_din    <= din_n;
      fifo_wren   <= wren_n;
      fifo_EOD_in <= eod_n;
    end
  end

endmodule

// File: tb/tb_rmii_receiver.sv
// Directed and randomized RMII streams; expected FIFO writes derived from a frame-level model of the dibit stream.
module tb_rmii_receiver;

  logic       REF_CLK    = 1'b0;
  logic       arst       = 1'b1;
  logic       CRS_DV     = 1'b0;
  logic       RXD0       = 1'b0;
  logic       RXD1       = 1'b0;
  logic       fifo_afull = 1'b0;
  logic [7:0] fifo_din;
  logic       fifo_wren;
  logic       fifo_EOD_in;

  int checks    = 0;
  int errors    = 0;
  int stray_eod = 0;

  logic [2:0] stim[$];
  logic [8:0] got[$];
  logic [8:0] exp[$];
  logic       last_crs = 1'b0;
  logic [7:0] bytes[$];

  always #10 REF_CLK = ~REF_CLK;

  rmii_receiver dut (
    .REF_CLK    (REF_CLK),
    .arst       (arst),
    .CRS_DV     (CRS_DV),
    .RXD0       (RXD0),
    .RXD1       (RXD1),
    .fifo_afull (fifo_afull),
    .fifo_din   (fifo_din),
    .fifo_wren  (fifo_wren),
    .fifo_EOD_in(fifo_EOD_in)
  );

  always @(negedge REF_CLK) begin
    if (fifo_wren === 1'b1) got.push_back({fifo_EOD_in, fifo_din});
    if (fifo_EOD_in === 1'b1 && fifo_wren !== 1'b1) stray_eod++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic void push(input logic crs, input logic [1:0] d);
    stim.push_back({crs, d});
    last_crs = crs;
  endfunction

  function automatic void add_pre(input int n, input bit mix00);
    for (int i = 0; i < n; i++)
      push(1'b1, (mix00 && i > 0 && $urandom_range(3) == 0) ? 2'b00 : 2'b01);
    push(1'b1, 2'b11);
  endfunction

  function automatic void add_byte(input logic [7:0] b, input int tog_pct);
    for (int j = 0; j < 4; j++)
      push((last_crs && int'($urandom_range(99)) < tog_pct) ? 1'b0 : 1'b1, b[2*j +: 2]);
  endfunction

  function automatic void add_end();
    push(1'b0, 2'($urandom_range(3)));
    push(1'b0, 2'($urandom_range(3)));
  endfunction

  function automatic void add_idle(input int n);
    for (int i = 0; i < n; i++) push(1'b0, 2'b00);
  endfunction

  // Frame-level reading of the stream: collect dibits after SFD, stop at the second consecutive low,
  // drop the two trailing lows, keep only whole bytes, flag the last one.
  function automatic void model();
    int         st = 0;
    logic [1:0] dl[$];
    exp.delete();
    for (int i = 0; i < stim.size(); i++) begin
      logic       crs      = stim[i][2];
      logic [1:0] d        = stim[i][1:0];
      logic       prev_low = (i > 0) && !stim[i-1][2];
      case (st)
        0: if (crs && d == 2'b01) st = 1;
        1: begin
          if (!crs) st = 0;
          else if (d == 2'b11) begin st = 2; dl.delete(); end
          else if (d == 2'b10) st = 3;
        end
        2: begin
          if (!crs && prev_low) begin
            int n;
            void'(dl.pop_back());
            n = dl.size() / 4;
            for (int k = 0; k < n; k++) begin
              logic [7:0] b = 8'h00;
              for (int j = 0; j < 4; j++) b[2*j +: 2] = dl[4*k + j];
              exp.push_back({k == n - 1, b});
            end
            st = 0;
          end else begin
            dl.push_back(d);
          end
        end
        default: if (!crs && prev_low) st = 0;
      endcase
    end
  endfunction

  task automatic play_range(input int a, input int b);
    for (int i = a; i < b; i++) begin
      @(negedge REF_CLK);
      CRS_DV = stim[i][2];
      RXD1   = stim[i][1];
      RXD0   = stim[i][0];
    end
  endtask

  task automatic compare_frame(input string tag);
    chk({tag, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk(tag, 32'(got[i]), 32'(exp[i]));
    got.delete();
  endtask

  initial begin
    // Reset and idle line
    #50;
    chk("rst_wren", 32'(fifo_wren), 32'd0);
    chk("rst_eod", 32'(fifo_EOD_in), 32'd0);
    chk("rst_din", 32'(fifo_din), 32'd0);
    #50 arst = 1'b0;
    stim.delete(); add_idle(50);
    play_range(0, stim.size());
    chk("idle_writes", got.size(), 0);
    chk("idle_din", 32'(fifo_din), 32'd0);

    // Basic frame of 0xCC bytes
    stim.delete(); add_pre(31, 1'b0);
    for (int k = 0; k < 25; k++) add_byte(8'hCC, 0);
    add_end(); add_idle(3);
    model(); play_range(0, stim.size());
    chk("basic_n", got.size(), 25);
    compare_frame("basic");

    // CRS_DV toggling at the tail carries data
    stim.delete(); add_pre(31, 1'b0);
    for (int k = 0; k < 25; k++) add_byte(8'hCC, 0);
    for (int i = 0; i < 12; i++) push(i % 2 == 1, 2'b11);
    add_end(); add_idle(3);
    model(); play_range(0, stim.size());
    chk("toggle_n", got.size(), 28);
    chk("toggle_last", got.size() == 28 ? 32'(got[27]) : 32'h0, 32'h1FF);
    compare_frame("toggle");

    // Partial trailing byte dropped
    stim.delete(); add_pre(15, 1'b0);
    for (int k = 0; k < 4; k++) add_byte(8'($urandom), 0);
    push(1'b1, 2'b10); push(1'b1, 2'b01);
    add_end(); add_idle(3);
    model(); play_range(0, stim.size());
    chk("partial_n", got.size(), 4);
    compare_frame("partial");

    // Overflow: afull rises after byte 5 completes
    stim.delete(); bytes.delete(); add_pre(7, 1'b0);
    for (int k = 0; k < 20; k++) begin
      bytes.push_back(8'($urandom));
      add_byte(bytes[k], 0);
    end
    add_end(); add_idle(3);
    play_range(0, 28);
    @(posedge REF_CLK); #1 fifo_afull = 1'b1;
    play_range(28, stim.size());
    fifo_afull = 1'b0;
    exp.delete();
    for (int k = 0; k < 5; k++) exp.push_back({k == 4, bytes[k]});
    compare_frame("overflow");
    stim.delete(); add_pre(9, 1'b0);
    for (int k = 0; k < 6; k++) add_byte(8'($urandom), 0);
    add_end(); add_idle(3);
    model(); play_range(0, stim.size());
    chk("after_ovf_n", got.size(), 6);
    compare_frame("after_ovf");

    // Bad preamble then a valid frame
    stim.delete();
    push(1'b1, 2'b01); push(1'b1, 2'b10); push(1'b1, 2'b11);
    for (int k = 0; k < 3; k++) add_byte(8'($urandom), 0);
    add_end(); add_pre(7, 1'b0);
    add_byte(8'h5A, 0); add_byte(8'hC3, 0);
    add_end(); add_idle(3);
    model(); play_range(0, stim.size());
    chk("badpre_n", got.size(), 2);
    compare_frame("badpre");

    // Reset while a write strobe is high
    stim.delete(); bytes.delete(); add_pre(5, 1'b0);
    for (int k = 0; k < 6; k++) begin
      bytes.push_back(8'($urandom));
      add_byte(bytes[k], 0);
    end
    play_range(0, 18);
    @(posedge REF_CLK); #2 arst = 1'b1;
    #1;
    chk("midrst_wren", 32'(fifo_wren), 32'd0);
    chk("midrst_eod", 32'(fifo_EOD_in), 32'd0);
    chk("midrst_din", 32'(fifo_din), 32'd0);
    @(negedge REF_CLK); @(negedge REF_CLK); arst = 1'b0;
    stim.delete(); add_idle(6);
    play_range(0, stim.size());
    chk("midrst_n", got.size(), 1);
    chk("midrst_byte", got.size() > 0 ? 32'(got[0]) : 32'h3FF, {24'd0, 1'b0, bytes[0]});
    got.delete();

    // Randomized back-to-back frames with toggles, 00 preamble dibits and partial bytes
    stim.delete();
    for (int f = 0; f < 6; f++) begin
      add_pre(int'($urandom_range(31, 1)), 1'b1);
      for (int k = 0; k < int'($urandom_range(10, 1)); k++) add_byte(8'($urandom), 25);
      for (int k = 0; k < int'($urandom_range(3)); k++) push(1'b1, 2'($urandom_range(3)));
      add_end();
    end
    add_idle(3);
    model(); play_range(0, stim.size());
    compare_frame("random");

    chk("stray_eod", stray_eod, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
